// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a small TX FIFO, a serialiser drains it,
// and loads return FIFO/serialiser status so firmware can poll before writing.
module mmio_uart_tx #(
    parameter int unsigned          DATA_W       = 16,
    parameter int unsigned          ADDR_W       = 8,
    parameter logic [ADDR_W-1:0]    BASE_ADDR    = 8'hF0,
    parameter int unsigned          CLKS_PER_BIT = 16,
    parameter int unsigned          FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_we,
    input  logic              bus_re,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              tx,
    output logic              tx_busy
);

    localparam int unsigned       PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned       BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = BASE_ADDR + 1'b1;
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    DEPTH       = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              overflow;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic sel_data, sel_status, full, empty, baud_done;
    logic push_req, push, pop, ovf_set, ovf_clr;
    logic [DATA_W-1:0] status_word;
    logic unused_wdata;

    assign sel_data   = (bus_addr == BASE_ADDR);
    assign sel_status = (bus_addr == STATUS_ADDR);
    assign full       = (count == DEPTH);
    assign empty      = (count == '0);
    assign baud_done  = (baud_cnt == BAUD_LAST);

    // The serialiser only pops from registered state, so a byte pushed into an empty FIFO
    // is taken one cycle later; a pop on the final stop cycle chains frames with no gap.
    assign pop      = !empty && (state == IDLE || (state == STOP && baud_done));
    assign push_req = bus_we && sel_data;
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = bus_we && sel_status && bus_wdata[3];

    assign unused_wdata = ^bus_wdata[DATA_W-1:8];

    always_comb begin
        // NOTE: assign a default before the field writes so no path leaves bits unassigned (no latch).
        status_word      = '0;
        status_word[0]   = full;
        status_word[1]   = empty;
        status_word[2]   = (state != IDLE);
        status_word[3]   = overflow;
        status_word[6:4] = 3'(count);
    end

    // NOTE: FIFO storage carries no reset; validity is defined entirely by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && push) fifo_mem[wr_ptr] <= bus_wdata[7:0];
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            // Line level follows the state one cycle later, keeping tx glitch-free.
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase
            tx_busy <= !empty || (state != IDLE);

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= fifo_mem[rd_ptr];
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         bus_rdata <= '0;
        else if (bus_re) bus_rdata <= sel_status ? status_word : '0;
    end

endmodule
